// File: rtl/iob_pad_arbiter_if.sv
// Pad-arbiter bus: per-requester request/release/drive controls, the IOBUF
// hookup and the registered read-back. master = requester side, slave = arbiter.
interface iob_pad_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] oe_req;
   logic [NREQ-1:0] wr_data;
   logic            pad_o;
   logic [NREQ-1:0] gnt;
   logic            pad_i;
   logic            pad_t;
   logic            rd_data;
   logic            rd_valid;
   logic            timeout;

   modport master (
      output req, done, oe_req, wr_data, pad_o,
      input  gnt, pad_i, pad_t, rd_data, rd_valid, timeout
   );

   modport slave (
      input  req, done, oe_req, wr_data, pad_o,
      output gnt, pad_i, pad_t, rd_data, rd_valid, timeout
   );
endinterface

// File: rtl/iob_pad_arbiter.sv
// Round-robin arbiter for one shared bidirectional pad. A winner is latched,
// the pad idles high-Z for TURNAROUND cycles, then the owner drives or samples
// it until done, request drop or MAX_HOLD. All outputs are registers, so the
// async reset tri-states the pad without waiting for a clock.
module iob_pad_arbiter #(
   parameter int NREQ       = 4,
   parameter int TURNAROUND = 2,
   parameter int MAX_HOLD   = 16
) (
   input logic              clk,
   input logic              rst_n,
   iob_pad_arbiter_if.slave bus
);
   localparam int SW = $clog2(NREQ);
   // Last TURN cycle index. With TURNAROUND=0 a hand-over still spends one
   // high-Z cycle in TURN so gnt is never handed directly between owners.
   localparam int TL = (TURNAROUND == 0) ? 0 : TURNAROUND - 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_t;

   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   r_sel, w_sel_nxt;
   logic [SW-1:0]   r_last, w_last_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic [7:0]      r_hold, w_hold_nxt;
   logic [NREQ-1:0] r_gnt, w_gnt_nxt;
   logic            r_pad_t, w_pad_t_nxt;
   logic            r_pad_i, w_pad_i_nxt;
   logic            r_rd_data, w_rd_data_nxt;
   logic            r_rd_valid, w_rd_valid_nxt;
   logic            r_timeout, w_timeout_nxt;

   logic [SW-1:0]   w_rr_idle;
   logic [SW-1:0]   w_rr_rel;
   logic            w_max;
   logic            w_rel;

   // First set request searching upward from last+1, wrapping; returns last
   // itself only if it is the sole requester.
   function automatic logic [SW-1:0] f_rr(input logic [NREQ-1:0] r,
                                          input logic [SW-1:0]   last);
      int idx;
      f_rr = last;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (r[SW'(idx)]) f_rr = SW'(idx);
      end
   endfunction

   // On release the owner becomes last, so the search starts past it.
   assign w_rr_idle = f_rr(bus.req, r_last);
   assign w_rr_rel  = f_rr(bus.req, r_sel);
   assign w_max     = (r_hold == 8'(MAX_HOLD - 1));
   assign w_rel     = bus.done[r_sel] | ~bus.req[r_sel] | w_max;

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt    = r_state;
      w_sel_nxt      = r_sel;
      w_last_nxt     = r_last;
      w_cnt_nxt      = r_cnt;
      w_hold_nxt     = r_hold;
      w_gnt_nxt      = '0;
      w_pad_t_nxt    = 1'b1;
      w_pad_i_nxt    = r_pad_i;
      w_rd_data_nxt  = r_rd_data;
      w_rd_valid_nxt = 1'b0;
      w_timeout_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|bus.req) begin
               w_sel_nxt = w_rr_idle;
               if (TURNAROUND == 0) begin
                  w_state_nxt = S_OWN;
                  w_hold_nxt  = '0;
                  w_gnt_nxt   = ONE << w_rr_idle;
               end else begin
                  w_state_nxt = S_TURN;
                  w_cnt_nxt   = '0;
               end
            end
         end
         S_TURN: begin
            if (r_cnt == 4'(TL)) begin
               w_state_nxt = S_OWN;
               w_hold_nxt  = '0;
               w_gnt_nxt   = ONE << r_sel;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_OWN: begin
            w_pad_i_nxt = bus.wr_data[r_sel];
            w_hold_nxt  = r_hold + 8'd1;
            if (w_rel) begin
               w_last_nxt    = r_sel;
               w_timeout_nxt = w_max & ~bus.done[r_sel] & bus.req[r_sel];
               if (|bus.req) begin
                  w_sel_nxt   = w_rr_rel;
                  w_state_nxt = S_TURN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_gnt_nxt   = ONE << r_sel;
               w_pad_t_nxt = ~bus.oe_req[r_sel];
               // Pad was high-Z this cycle, so pad_o carries the far end.
               if (r_pad_t) begin
                  w_rd_data_nxt  = bus.pad_o;
                  w_rd_valid_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset releases the pad immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_last     <= SW'(NREQ - 1);
         r_cnt      <= '0;
         r_hold     <= '0;
         r_gnt      <= '0;
         r_pad_t    <= 1'b1;
         r_pad_i    <= 1'b0;
         r_rd_data  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_last     <= w_last_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hold     <= w_hold_nxt;
         r_gnt      <= w_gnt_nxt;
         r_pad_t    <= w_pad_t_nxt;
         r_pad_i    <= w_pad_i_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.pad_t    = r_pad_t;
   assign bus.pad_i    = r_pad_i;
   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.timeout  = r_timeout;
endmodule

// File: doc/iob_pad_arbiter.md
IOB_PAD_ARBITER -- requirements
Module: iob_pad_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one bidirectional pad (2..8).
REQ-002 SHALL have parameter TURNAROUND, default 2, high-Z cycles between owners (0..15).
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum cycles one owner holds the pad (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  NREQ  per-requester ownership request, level.
REQ-007 SHALL have port done  input  NREQ  per-requester release; honoured only from the current owner.
REQ-008 SHALL have port oe_req  input  NREQ  owner wants to drive (1) or sample (0).
REQ-009 SHALL have port wr_data  input  NREQ  value each requester would drive.
REQ-010 SHALL have port pad_o  input  1  from IOBUF O.
REQ-011 SHALL have port gnt  output  NREQ  one-hot grant, or all zero.
REQ-012 SHALL have port pad_i  output  1  to IOBUF I.
REQ-013 SHALL have port pad_t  output  1  to IOBUF T; 1 = high-Z.
REQ-014 SHALL have port rd_data  output  1  registered pad sample.
REQ-015 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-016 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-017 SHALL implement FSM states IDLE, TURN, OWN; every output SHALL be registered.
REQ-018 IDLE: gnt=0, pad_t=1; any req bit set -> select winner, go TURN (or OWN when TURNAROUND=0).
REQ-019 Winner SHALL be chosen round-robin: first set req bit searching upward from (last_owner+1) mod NREQ.
REQ-020 TURN: gnt=0, pad_t=1 for exactly TURNAROUND cycles, then OWN; the winner is latched at selection and not re-evaluated.
REQ-021 OWN: gnt[sel]=1; each cycle pad_t <= ~oe_req[sel], pad_i <= wr_data[sel] (one-cycle latency).
REQ-022 OWN with pad_t=1 in the previous cycle: rd_data <= pad_o, rd_valid <= 1; otherwise rd_valid <= 0.
REQ-023 Hold counter SHALL clear on entering OWN and increment each OWN cycle.
REQ-024 Release SHALL occur on done[sel]=1, req[sel]=0, or hold count reaching MAX_HOLD; simultaneous causes count as one release.
REQ-025 Release from MAX_HOLD only (no done, req still high) SHALL pulse timeout for one cycle.
REQ-026 Release cycle + 1: gnt=0, pad_t=1, rd_valid=0, last_owner=sel.
REQ-027 On release, with any req bit set (including sel), SHALL select next winner in the same cycle and go TURN; otherwise IDLE.
REQ-028 A released owner SHALL win again only when no other requester is pending.
REQ-029 done bits from non-owners and done with req=0 in IDLE SHALL be ignored.
REQ-030 pad_t SHALL never be 0 while gnt is zero; two owners SHALL never be granted in the same cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, gnt=0, pad_t=1, pad_i=0, rd_data=0, rd_valid=0, timeout=0, hold=0, last_owner=NREQ-1.
REQ-032 Reset asserted mid-OWN SHALL tri-state the pad asynchronously without waiting for a clock edge.
REQ-033 After deassertion, the first grant SHALL go to requester 0 when it is requesting.

Verification (NREQ=4, TURNAROUND=2, MAX_HOLD=16)
REQ-034 req=4'b0001 from cycle 0, oe_req[0]=1, wr_data[0]=1 -> pad_t=1 cycles 1-2; gnt=0001 at cycle 3; pad_t=0, pad_i=1 at cycle 4.
REQ-035 req=4'b1111 held, each owner pulses done after 3 cycles -> grant order 0,1,2,3,0 with 2 high-Z cycles between each owner.
REQ-036 Owner 2 holds req with no done -> timeout pulse after the 16th OWN cycle; gnt=0, pad_t=1 the next cycle.
REQ-037 Owner 1 with oe_req=0, pad_o toggling 0,1,1 -> rd_data follows one cycle later with rd_valid=1.
REQ-038 rst_n pulled low mid-OWN with pad_t=0 -> pad_t=1 and gnt=0 before the next clk edge; after release with req=4'b1001 -> requester 0 granted first.
REQ-039 done[3] asserted while requester 1 owns -> no release; owner 1 keeps gnt until its own done.
